// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and state encoding for the display arbiter
package seg7_pkg;

  localparam int DW_DEF    = 32;
  localparam int MAX_N_REQ = 8;
  localparam int OWNER_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_disp_arbiter_rr_pick.sv
// rtl/seg7_disp_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick
  import seg7_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [OWNER_W-1:0] last,
  output logic [OWNER_W-1:0] winner,
  output logic               any_req
);

  // Scan from last+1 upward with wrap; the last owner itself is checked last.
  always_comb begin
    int  idx;
    logic found;
    winner  = last;
    any_req = |req;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = OWNER_W'(idx);
      end
    end
  end

endmodule

// File: rtl/seg7_disp_arbiter.sv
// rtl/seg7_disp_arbiter.sv - round-robin owner of the seven-segment display with minimum dwell
module seg7_disp_arbiter
  import seg7_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DWELL = 50_000_000,
  parameter int DW    = DW_DEF
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [OWNER_W-1:0]  owner,
  output logic                disp_valid,
  output logic [DW-1:0]       disp_data
);

  localparam int CW = $clog2(DWELL);
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  state_t               state, next_state;
  logic [CW-1:0]        dwell_cnt, next_cnt;
  logic [N_REQ-1:0]     next_gnt;
  logic [OWNER_W-1:0]   next_owner;
  logic [DW-1:0]        next_data;
  logic [OWNER_W-1:0]   winner;
  logic                 any_req;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .last    (owner),
    .winner  (winner),
    .any_req (any_req)
  );

  // Valid exactly while in OWN, which is exactly when one gnt bit is set.
  assign disp_valid = (state == OWN);

  // Next-state logic: arbitration from IDLE, drop/handover/dwell counting in OWN.
  always_comb begin
    int oi;
    next_state = state;
    next_gnt   = gnt;
    next_owner = owner;
    next_cnt   = dwell_cnt;
    next_data  = disp_data;
    oi         = int'(owner);
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = OWN;
          next_gnt   = N_REQ'(1) << winner;
          next_owner = winner;
          next_cnt   = '0;
        end
      end
      OWN: begin
        next_data = req_data[oi*DW +: DW];
        if (!req[oi]) begin
          // A dropped request beats dwell expiry.
          next_state = IDLE;
          next_gnt   = '0;
          next_cnt   = '0;
        end else if (dwell_cnt == CNT_MAX) begin
          // Owner's own bit is searched last, so winner != owner means another requester.
          if (winner != owner) begin
            next_gnt   = N_REQ'(1) << winner;
            next_owner = winner;
            next_cnt   = '0;
          end
        end else begin
          next_cnt = dwell_cnt + 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        next_gnt   = '0;
      end
    endcase
  end

  // Register bank; reset leaves owner at the top index so requester 0 wins first.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= OWNER_W'(N_REQ - 1);
      dwell_cnt <= '0;
      disp_data <= '0;
    end else begin
      state     <= next_state;
      gnt       <= next_gnt;
      owner     <= next_owner;
      dwell_cnt <= next_cnt;
      disp_data <= next_data;
    end
  end

endmodule
